// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One digit per slot, a dark guard interval at the start of each slot, tear-free value commit per frame.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_MAX    = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [VW-1:0]   display, pending;
  logic [NUM_DIGITS-1:0] blanked;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]      seg_nxt;
  logic            dp_nxt;
  logic            commit;
  logic [3:0]      cur_digit;

  // Active-low decode, bit 0 = segment a.
  function automatic logic [6:0] hexto7segment(input logic [3:0] hex);
    case (hex)
      4'h0: hexto7segment = 7'h40;
      4'h1: hexto7segment = 7'h79;
      4'h2: hexto7segment = 7'h24;
      4'h3: hexto7segment = 7'h30;
      4'h4: hexto7segment = 7'h19;
      4'h5: hexto7segment = 7'h12;
      4'h6: hexto7segment = 7'h02;
      4'h7: hexto7segment = 7'h78;
      4'h8: hexto7segment = 7'h00;
      4'h9: hexto7segment = 7'h10;
      4'hA: hexto7segment = 7'h08;
      4'hB: hexto7segment = 7'h03;
      4'hC: hexto7segment = 7'h46;
      4'hD: hexto7segment = 7'h21;
      4'hE: hexto7segment = 7'h06;
      default: hexto7segment = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    logic nz;
    nz      = 1'b0;
    blanked = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz         = nz | (|display[4*i +: 4]);
      blanked[i] = lz_blank && !nz && (i != 0);
    end
  end

  assign cur_digit = display[4*idx +: 4];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    commit    = 1'b0;
    an_nxt    = '1;
    seg_nxt   = 7'h7F;
    dp_nxt    = 1'b1;
    if (!en) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      if (state == DRIVE && !blanked[idx]) begin
        an_nxt  = ~(AN_ONE << idx);
        seg_nxt = hexto7segment(cur_digit);
        dp_nxt  = ~dp_in[idx];
      end
      if (cnt == CNT_MAX) begin
        cnt_nxt   = '0;
        state_nxt = BLANK;
        commit    = (idx == IDX_MAX);
        idx_nxt   = (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
        cnt_nxt   = cnt + CW'(1);
        // Next count reaching GUARD_CYCLES ends the dark interval.
        state_nxt = (cnt >= GUARD_LAST) ? DRIVE : BLANK;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      pending    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= commit;
      if (load) pending <= value_in;
      // A load on the commit edge bypasses pending and never raises busy.
      if (commit) begin
        display <= load ? value_in : pending;
        busy    <= 1'b0;
      end else if (load) begin
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
// Sample index k counts falling edges after the commit edge; digit d is dark at k=8d+1..8d+2, lit at 8d+3..8d+8.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .en(en), .value_in(value_in), .load(load),
    .dp_in(dp_in), .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  dpin;
    int          digit;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic goto(input int target);
    while (k < target) step();
  endtask

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      miscompares++;
      vectors++;
      $display("FAIL frame_done timeout: got 0, expected pulse within 200 cycles");
    end
    k = 0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 1'b0, 4'h0, 0, 4'b1110, 7'h19, 1'b1};
    vecs[1]  = '{16'h1234, 1'b0, 4'h0, 1, 4'b1101, 7'h30, 1'b1};
    vecs[2]  = '{16'h1234, 1'b0, 4'h0, 2, 4'b1011, 7'h24, 1'b1};
    vecs[3]  = '{16'h1234, 1'b0, 4'h0, 3, 4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h0050, 1'b1, 4'h0, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[5]  = '{16'h0050, 1'b1, 4'h0, 2, 4'b1111, 7'h7F, 1'b1};
    vecs[6]  = '{16'h0050, 1'b1, 4'h0, 1, 4'b1101, 7'h12, 1'b1};
    vecs[7]  = '{16'h0050, 1'b1, 4'h0, 0, 4'b1110, 7'h40, 1'b1};
    vecs[8]  = '{16'h0000, 1'b1, 4'h0, 1, 4'b1111, 7'h7F, 1'b1};
    vecs[9]  = '{16'h0000, 1'b1, 4'h0, 0, 4'b1110, 7'h40, 1'b1};
    vecs[10] = '{16'hABCD, 1'b0, 4'h0, 0, 4'b1110, 7'h21, 1'b1};
    vecs[11] = '{16'hABCD, 1'b0, 4'h0, 3, 4'b0111, 7'h08, 1'b1};
    vecs[12] = '{16'hABCD, 1'b0, 4'h0, 1, 4'b1101, 7'h46, 1'b1};
    vecs[13] = '{16'hABCD, 1'b0, 4'h0, 2, 4'b1011, 7'h03, 1'b1};
    vecs[14] = '{16'h1234, 1'b0, 4'h4, 2, 4'b1011, 7'h24, 1'b0};
    vecs[15] = '{16'h1234, 1'b0, 4'h4, 1, 4'b1101, 7'h30, 1'b1};
    vecs[16] = '{16'h5678, 1'b0, 4'h0, 0, 4'b1110, 7'h00, 1'b1};
    vecs[17] = '{16'h5678, 1'b0, 4'h0, 1, 4'b1101, 7'h78, 1'b1};
    vecs[18] = '{16'h5678, 1'b0, 4'h0, 2, 4'b1011, 7'h02, 1'b1};
    vecs[19] = '{16'h9EF0, 1'b0, 4'h0, 1, 4'b1101, 7'h0E, 1'b1};
    vecs[20] = '{16'h9EF0, 1'b0, 4'h0, 2, 4'b1011, 7'h06, 1'b1};
    vecs[21] = '{16'h9EF0, 1'b0, 4'h0, 3, 4'b0111, 7'h10, 1'b1};
    vecs[22] = '{16'h9EF0, 1'b1, 4'h0, 0, 4'b1110, 7'h40, 1'b1};
    vecs[23] = '{16'h0100, 1'b1, 4'h0, 1, 4'b1101, 7'h40, 1'b1};

    reset = 1'b1; en = 1'b1; value_in = '0; load = 1'b0; dp_in = '0; lz_blank = 1'b0;
    #1;
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp", 32'(dp), 32'h1);
    check("reset busy", 32'(busy), 32'h0);
    check("reset frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table of per-digit expectations: load, commit, then inspect the slot.
    for (int v = 0; v < 24; v++) begin
      lz_blank = vecs[v].lz;
      dp_in    = vecs[v].dpin;
      wait_frame();
      pulse_load(vecs[v].value);
      check($sformatf("v%0d busy after load", v), 32'(busy), 32'h1);
      wait_frame();
      check($sformatf("v%0d busy after commit", v), 32'(busy), 32'h0);
      goto(8 * vecs[v].digit + 1);
      check($sformatf("v%0d guard1 an", v), 32'(an), 32'hF);
      check($sformatf("v%0d guard1 dp", v), 32'(dp), 32'h1);
      step();
      check($sformatf("v%0d guard2 an", v), 32'(an), 32'hF);
      check($sformatf("v%0d guard2 seg", v), 32'(seg), 32'h7F);
      step();
      check($sformatf("v%0d an", v), 32'(an), 32'(vecs[v].exp_an));
      check($sformatf("v%0d seg", v), 32'(seg), 32'(vecs[v].exp_seg));
      check($sformatf("v%0d dp", v), 32'(dp), 32'(vecs[v].exp_dp));
      goto(8 * vecs[v].digit + 8);
      check($sformatf("v%0d last an", v), 32'(an), 32'(vecs[v].exp_an));
    end

    // Slot timing over one whole frame of 0x1234.
    lz_blank = 1'b0; dp_in = '0;
    wait_frame();
    pulse_load(16'h1234);
    wait_frame();
    for (int i = 1; i <= 32; i++) begin
      int d;
      int pos;
      logic [3:0] exp_an;
      step();
      d = (i - 1) / 8;
      pos = (i - 1) % 8;
      exp_an = (pos < 2) ? 4'hF : ~(4'b0001 << d);
      check($sformatf("timing an k=%0d", i), 32'(an), 32'(exp_an));
      check($sformatf("timing frame_done k=%0d", i), 32'(frame_done), (i == 32) ? 32'h1 : 32'h0);
    end
    k = 0;

    // Mid-frame load is held until the frame ends.
    goto(11);
    pulse_load(16'hABCD);
    check("midload busy", 32'(busy), 32'h1);
    goto(21);
    check("midload digit2 seg", 32'(seg), 32'h24);
    goto(29);
    check("midload digit3 seg", 32'(seg), 32'h79);
    check("midload busy held", 32'(busy), 32'h1);
    goto(32);
    check("midload frame_done", 32'(frame_done), 32'h1);
    check("midload busy cleared", 32'(busy), 32'h0);
    k = 0;
    goto(5);  check("new frame d0", 32'(seg), 32'h21);
    goto(13); check("new frame d1", 32'(seg), 32'h46);
    goto(21); check("new frame d2", 32'(seg), 32'h03);
    goto(29); check("new frame d3", 32'(seg), 32'h08);

    // Load coinciding with the commit edge.
    goto(31);
    pulse_load(16'h5555);
    check("edge load frame_done", 32'(frame_done), 32'h1);
    check("edge load busy", 32'(busy), 32'h0);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("edge load busy stays 0", 32'(busy), 32'h0);
    end
    goto(5);
    check("edge load committed", 32'(seg), 32'h12);

    // Asynchronous reset during a lit cycle, then en low with a load.
    #2 reset = 1'b1;
    #1;
    check("async reset an", 32'(an), 32'hF);
    check("async reset seg", 32'(seg), 32'h7F);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    pulse_load(16'h0007);
    check("en0 load busy", 32'(busy), 32'h1);
    check("en0 an", 32'(an), 32'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      check("en0 an dark", 32'(an), 32'hF);
      check("en0 no frame_done", 32'(frame_done), 32'h0);
    end
    en = 1'b1;
    k  = 0;
    goto(2);
    check("restart guard an", 32'(an), 32'hF);
    step();
    check("restart digit0 an", 32'(an), 32'hE);
    check("restart value lost", 32'(seg), 32'h40);
    goto(11);
    check("restart digit1 an", 32'(an), 32'hD);
    goto(32);
    check("restart frame_done", 32'(frame_done), 32'h1);
    check("restart busy cleared", 32'(busy), 32'h0);
    k = 0;
    goto(5);
    check("restart pending shown", 32'(seg), 32'h78);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
